regfile_wb_buffer: RTL and testbench
====================================

REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter ZERO_REG_ZERO, default 1; when 1, writes to x0 are discarded.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid  in  2, in_ready  out  2  per-producer handshake; port 0 is ALU, port 1 is LSU.
REQ-007 SHALL have ports in_addr  in  2x5, in_data  in  2xDATA_WIDTH  result destination and value.
REQ-008 SHALL have port wb_stall  in  1  when high, no entry drains.
REQ-009 SHALL have ports waddr  out  2x5, wdata  out  2xDATA_WIDTH, we  out  2  regfile write ports.
REQ-010 SHALL have ports fwd_addr  in  5, fwd_hit  out  1, fwd_data  out  DATA_WIDTH  pending-write lookup.
REQ-011 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL hold entries in a FIFO ordered oldest to newest.
REQ-013 SHALL drive in_ready[0]=(count<=DEPTH-1) and in_ready[1]=(count<=DEPTH-2), both from registered count only, never from same-cycle drain.
REQ-014 SHALL enqueue port i when in_valid[i]&&in_ready[i]; when both enqueue in one cycle, port 0 entry is older.
REQ-015 SHALL accept, but not store, a handshake with in_addr==0 when ZERO_REG_ZERO=1.
REQ-016 SHALL present the head entry on write port 0 and head+1 on write port 1, combinationally from stored state; an entry enqueued at edge N is first visible after edge N.
REQ-017 SHALL, when wb_stall=0, drive we[k]=1 for each of min(count,2) head entries and pop them at the next edge.
REQ-018 SHALL drive we=0 while wb_stall=1 and retain all entries.
REQ-019 SHALL, when both drained entries share an address, drive we[0]=0, we[1]=1, and still pop both.
REQ-020 SHALL update count as count+enqueued-drained in one edge; simultaneous enqueue and drain at full or empty SHALL be legal.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL drive waddr/wdata to 0 on ports with we=0.

Reset
REQ-023 SHALL, with rst=1 at an edge, set count=0 and both pointers to 0, discarding pending entries, including mid-drain.
REQ-024 SHALL, during and after reset until an enqueue, output we=0, waddr=0, wdata=0, fwd_hit=0, fwd_data=0, in_ready=2'b11.
REQ-025 SHALL ignore in_valid in a cycle with rst=1.

Configuration
REQ-026 SHALL compile the forwarding lookup only when macro REGFILE_WB_FORWARD_EN is defined.
REQ-027 SHALL, with REGFILE_WB_FORWARD_EN, drive fwd_hit=1 and fwd_data=newest stored entry matching fwd_addr, combinationally; fwd_addr==0 never hits.
REQ-028 SHALL, without REGFILE_WB_FORWARD_EN, tie fwd_hit=0 and fwd_data=0 and have no match logic.

Verification
REQ-029 SHALL cover: in_valid=2'b01, addr 5, data 0xA -> next cycle we=2'b01, waddr[0]=5, wdata[0]=0xA; count returns to 0.
REQ-030 SHALL cover: wb_stall=1, four single enqueues with DEPTH=4 -> count=4, in_ready=2'b00, we=0; release stall -> two drains per cycle, oldest first.
REQ-031 SHALL cover: both ports valid, addr 7, ALU 0x1, LSU 0x2 -> we=2'b10, waddr[1]=7, wdata[1]=0x2.
REQ-032 SHALL cover: in_addr=0 with ZERO_REG_ZERO=1 -> in_ready=1, count stays 0, we stays 0.
REQ-033 SHALL cover, with REGFILE_WB_FORWARD_EN: stalled entries (3,0x11) then (3,0x22), fwd_addr=3 -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0.
REQ-034 SHALL cover: count=3 under stall, rst=1 for one edge -> count=0, we=0, in_ready=2'b11 next cycle.

Source files
------------

// File: rtl/regfile_wb_buffer.sv
// Two-producer register writeback buffer: FIFO of pending (addr, data) results drained two per cycle.
// Optional pending-write forwarding lookup is built only when REGFILE_WB_FORWARD_EN is defined.
module regfile_wb_buffer #(
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 4,
    parameter int ZERO_REG_ZERO = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 in_valid,
    output logic [1:0]                 in_ready,
    input  logic [1:0][4:0]            in_addr,
    input  logic [1:0][DATA_WIDTH-1:0] in_data,
    input  logic                       wb_stall,
    output logic [1:0][4:0]            waddr,
    output logic [1:0][DATA_WIDTH-1:0] wdata,
    output logic [1:0]                 we,
    input  logic [4:0]                 fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LIM_P0 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LIM_P1 = CNT_W'(DEPTH - 2);

    logic [DEPTH-1:0][4:0]            r_mem_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem_data;
    logic [PTR_W-1:0]                 r_rd_ptr;
    logic [PTR_W-1:0]                 r_wr_ptr;
    logic [CNT_W-1:0]                 r_count;

    logic [1:0]       w_ready;
    logic [1:0]       w_acc;
    logic [1:0]       w_zero;
    logic [1:0]       w_store;
    logic [1:0]       w_pop;
    logic [PTR_W-1:0] w_head1_idx;
    logic [PTR_W-1:0] w_wr1_idx;
    logic [CNT_W-1:0] w_n_store;
    logic [CNT_W-1:0] w_n_pop;
    logic             w_same_addr;

    // Ready depends only on registered occupancy so a same-cycle drain never widens acceptance.
    assign w_ready   = {(r_count <= LIM_P1), (r_count <= LIM_P0)};
    assign in_ready  = rst ? 2'b11 : w_ready;
    assign w_acc     = in_valid & w_ready & {2{~rst}};
    assign w_zero[0] = (ZERO_REG_ZERO != 0) && (in_addr[0] == 5'd0);
    assign w_zero[1] = (ZERO_REG_ZERO != 0) && (in_addr[1] == 5'd0);
    assign w_store   = w_acc & ~w_zero;
    assign w_n_store = CNT_W'(w_store[0]) + CNT_W'(w_store[1]);

    assign w_head1_idx = r_rd_ptr + PTR_W'(1);
    assign w_wr1_idx   = r_wr_ptr + PTR_W'(1);
    assign w_pop[0]    = ~wb_stall & ~rst & (r_count >= CNT_W'(1));
    assign w_pop[1]    = ~wb_stall & ~rst & (r_count >= CNT_W'(2));
    assign w_n_pop     = CNT_W'(w_pop[0]) + CNT_W'(w_pop[1]);
    assign w_same_addr = (r_mem_addr[r_rd_ptr] == r_mem_addr[w_head1_idx]);
    assign count       = r_count;

    // Regfile write ports; an older write shadowed by a younger one to the same register is suppressed.
    always_comb begin
        we    = 2'b00;
        waddr = '0;
        wdata = '0;
        we[1] = w_pop[1];
        if (w_pop[1] && w_same_addr) begin
            we[0] = 1'b0;
        end else begin
            we[0] = w_pop[0];
        end
        if (we[0]) begin
            waddr[0] = r_mem_addr[r_rd_ptr];
            wdata[0] = r_mem_data[r_rd_ptr];
        end else begin
            waddr[0] = 5'd0;
            wdata[0] = '0;
        end
        if (we[1]) begin
            waddr[1] = r_mem_addr[w_head1_idx];
            wdata[1] = r_mem_data[w_head1_idx];
        end else begin
            waddr[1] = 5'd0;
            wdata[1] = '0;
        end
    end

    // Pointer, occupancy and storage update; port 0 lands in the older slot when both store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_count  <= r_count + w_n_store - w_n_pop;
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_pop);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_store);
            if (w_store[0]) begin
                r_mem_addr[r_wr_ptr] <= in_addr[0];
                r_mem_data[r_wr_ptr] <= in_data[0];
            end
            if (w_store[1]) begin
                r_mem_addr[w_store[0] ? w_wr1_idx : r_wr_ptr] <= in_addr[1];
                r_mem_data[w_store[0] ? w_wr1_idx : r_wr_ptr] <= in_data[1];
            end
        end
    end

`ifdef REGFILE_WB_FORWARD_EN
    // Scan oldest to newest so the newest matching pending write wins.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        v_idx    = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rd_ptr + PTR_W'(i);
            if (!rst && (CNT_W'(i) < r_count) && (fwd_addr != 5'd0) &&
                (r_mem_addr[v_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem_data[v_idx];
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end
`else
    logic w_fwd_addr_unused;
    assign w_fwd_addr_unused = ^fwd_addr;
    assign fwd_hit           = 1'b0;
    assign fwd_data          = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer (DEPTH=4, DATA_WIDTH=64, ZERO_REG_ZERO=1).
// Forwarding expectations follow REGFILE_WB_FORWARD_EN when the macro is defined.
module tb_regfile_wb_buffer;

    logic             clk;
    logic             rst;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][4:0]  in_addr;
    logic [1:0][63:0] in_data;
    logic             wb_stall;
    logic [1:0][4:0]  waddr;
    logic [1:0][63:0] wdata;
    logic [1:0]       we;
    logic [4:0]       fwd_addr;
    logic             fwd_hit;
    logic [63:0]      fwd_data;
    logic [2:0]       count;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_wb_buffer #(.DATA_WIDTH(64), .DEPTH(4), .ZERO_REG_ZERO(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
        .waddr(waddr), .wdata(wdata), .we(we),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out(input string tag);
        chk({tag, " we"}, 64'(we), 64'd0);
        chk({tag, " waddr"}, 64'(waddr), 64'd0);
        chk({tag, " wdata0"}, wdata[0], 64'd0);
        chk({tag, " wdata1"}, wdata[1], 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 2'b00;
        in_addr  = '0;
        in_data  = '0;
        wb_stall = 1'b0;
        fwd_addr = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst count", 64'(count), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd3);
        chk("rst fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst fwd_data", fwd_data, 64'd0);
        idle_out("rst");

        // single ALU result drains the following cycle
        in_valid = 2'b01; in_addr[0] = 5'd5; in_data[0] = 64'hA;
        tick();
        in_valid = 2'b00;
        chk("single count", 64'(count), 64'd1);
        chk("single we", 64'(we), 64'd1);
        chk("single waddr0", 64'(waddr[0]), 64'd5);
        chk("single wdata0", wdata[0], 64'hA);
        chk("single waddr1", 64'(waddr[1]), 64'd0);
        tick();
        chk("single count after", 64'(count), 64'd0);
        chk("single we after", 64'(we), 64'd0);

        // fill under stall, pointers wrap
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 2'b01; in_addr[0] = 5'(i); in_data[0] = 64'h100 + 64'(i);
            tick();
            if (i == 3) begin
                chk("fill3 in_ready", 64'(in_ready), 64'd1);
            end else begin
                chk("fill count", 64'(count), 64'(i));
            end
        end
        chk("full count", 64'(count), 64'd4);
        chk("full in_ready", 64'(in_ready), 64'd0);
        idle_out("stall");
        in_valid = 2'b01; in_addr[0] = 5'd9; in_data[0] = 64'h999;
        tick();
        chk("full reject count", 64'(count), 64'd4);
        in_valid = 2'b00;
        wb_stall = 1'b0;
        #1;
        chk("drain1 we", 64'(we), 64'd3);
        chk("drain1 waddr0", 64'(waddr[0]), 64'd1);
        chk("drain1 wdata0", wdata[0], 64'h101);
        chk("drain1 waddr1", 64'(waddr[1]), 64'd2);
        chk("drain1 wdata1", wdata[1], 64'h102);
        tick();
        chk("drain2 count", 64'(count), 64'd2);
        chk("drain2 waddr0", 64'(waddr[0]), 64'd3);
        chk("drain2 wdata1", wdata[1], 64'h104);
        tick();
        chk("drain3 count", 64'(count), 64'd0);
        chk("drain3 we", 64'(we), 64'd0);

        // both ports to the same register: older write suppressed
        in_valid = 2'b11; in_addr[0] = 5'd7; in_addr[1] = 5'd7;
        in_data[0] = 64'h1; in_data[1] = 64'h2;
        tick();
        in_valid = 2'b00;
        chk("same we", 64'(we), 64'd2);
        chk("same waddr1", 64'(waddr[1]), 64'd7);
        chk("same wdata1", wdata[1], 64'h2);
        chk("same waddr0", 64'(waddr[0]), 64'd0);
        chk("same wdata0", wdata[0], 64'd0);
        tick();
        chk("same count after", 64'(count), 64'd0);

        // x0 writes accepted but dropped
        in_valid = 2'b11; in_addr[0] = 5'd0; in_addr[1] = 5'd0;
        in_data[0] = 64'hFF; in_data[1] = 64'hEE;
        #1;
        chk("x0 in_ready", 64'(in_ready), 64'd3);
        tick();
        in_valid = 2'b00;
        chk("x0 count", 64'(count), 64'd0);
        chk("x0 we", 64'(we), 64'd0);

        // enqueue while draining: one drains, two enter
        in_valid = 2'b01; in_addr[0] = 5'd8; in_data[0] = 64'h80;
        tick();
        in_valid = 2'b11; in_addr[0] = 5'd9; in_addr[1] = 5'd10;
        in_data[0] = 64'h90; in_data[1] = 64'hA0;
        #1;
        chk("mix waddr0", 64'(waddr[0]), 64'd8);
        tick();
        in_valid = 2'b00;
        chk("mix count", 64'(count), 64'd2);
        chk("mix waddr0 b", 64'(waddr[0]), 64'd9);
        chk("mix waddr1 b", 64'(waddr[1]), 64'd10);
        chk("mix wdata1 b", wdata[1], 64'hA0);
        tick();
        chk("mix count after", 64'(count), 64'd0);

        // forwarding lookup on stalled entries
        wb_stall = 1'b1;
        in_valid = 2'b01; in_addr[0] = 5'd3; in_data[0] = 64'h11;
        tick();
        in_addr[0] = 5'd3; in_data[0] = 64'h22;
        tick();
        in_addr[0] = 5'd5; in_data[0] = 64'h33;
        tick();
        in_valid = 2'b00;
        chk("fwd count", 64'(count), 64'd3);
        fwd_addr = 5'd3;
        #1;
`ifdef REGFILE_WB_FORWARD_EN
        chk("fwd3 hit", 64'(fwd_hit), 64'd1);
        chk("fwd3 data", fwd_data, 64'h22);
        fwd_addr = 5'd5;
        #1;
        chk("fwd5 data", fwd_data, 64'h33);
`else
        chk("fwd3 hit off", 64'(fwd_hit), 64'd0);
        chk("fwd3 data off", fwd_data, 64'd0);
`endif
        fwd_addr = 5'd4;
        #1;
        chk("fwd4 hit", 64'(fwd_hit), 64'd0);
        fwd_addr = 5'd0;
        #1;
        chk("fwd0 hit", 64'(fwd_hit), 64'd0);
        chk("fwd0 data", fwd_data, 64'd0);

        // reset with three pending entries, input ignored during reset
        fwd_addr = 5'd3;
        rst = 1'b1; wb_stall = 1'b0;
        in_valid = 2'b01; in_addr[0] = 5'd6; in_data[0] = 64'h66;
        #1;
        chk("in rst we", 64'(we), 64'd0);
        chk("in rst in_ready", 64'(in_ready), 64'd3);
        tick();
        rst = 1'b0; in_valid = 2'b00;
        #1;
        chk("post rst count", 64'(count), 64'd0);
        chk("post rst in_ready", 64'(in_ready), 64'd3);
        chk("post rst fwd_hit", 64'(fwd_hit), 64'd0);
        idle_out("post rst");
        tick();
        chk("post rst idle count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
